// File: rtl/sprite_compositor.sv
// Two-sprite compositor and registered VGA output stage (2-cycle latency, syncs delay-matched).
// Define SPRITE_COMPOSITOR_COLLISION_EN to build the per-frame sprite-overlap (collision) logic.
module sprite_compositor #(
  parameter int          SPRITE_WIDTH    = 32,
  parameter int          SPRITE_HEIGHT   = 32,
  parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F,
  parameter logic [15:0] BG_COLOR        = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] current_pixel_x,
  input  logic [9:0] current_pixel_y,
  input  logic       video_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] p1_posx,
  input  logic [9:0] p1_posy,
  input  logic [9:0] p2_posx,
  input  logic [9:0] p2_posy,
  input  logic [15:0] p1_data,
  input  logic [15:0] p2_data,
  input  logic [15:0] bg_data,
  input  logic       bg_en,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_blank_n,
  output logic       collision_pulse,
  output logic       collision_frame,
  output logic [7:0] collision_count
);

  localparam logic [10:0] WIDTH_LIM  = 11'(SPRITE_WIDTH);
  localparam logic [10:0] HEIGHT_LIM = 11'(SPRITE_HEIGHT);

  // Offsets wrap in 10 bits exactly like the ROM address, so sprites straddle the edge cleanly.
  logic [9:0] p1_relx, p1_rely, p2_relx, p2_rely;
  logic       hit1, hit2;

  assign p1_relx = current_pixel_x - p1_posx;
  assign p1_rely = current_pixel_y - p1_posy;
  assign p2_relx = current_pixel_x - p2_posx;
  assign p2_rely = current_pixel_y - p2_posy;
  assign hit1    = ({1'b0, p1_relx} < WIDTH_LIM) && ({1'b0, p1_rely} < HEIGHT_LIM);
  assign hit2    = ({1'b0, p2_relx} < WIDTH_LIM) && ({1'b0, p2_rely} < HEIGHT_LIM);

  // Stage 1: registered alongside the ROM read so both land together in stage 2.
  logic hit1_q, hit2_q, video_on_q, hsync_q, vsync_q, bg_en_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      bg_en_q    <= 1'b0;
    end else begin
      hit1_q     <= hit1;
      hit2_q     <= hit2;
      video_on_q <= video_on;
      hsync_q    <= hsync_in;
      vsync_q    <= vsync_in;
      bg_en_q    <= bg_en;
    end
  end

  // Stage 2: transparency, priority and RGB565 -> RGB888 expansion.
  logic        o1, o2;
  logic [15:0] pix;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    o1  = hit1_q && (p1_data != TRANSPARENT_KEY);
    o2  = hit2_q && (p2_data != TRANSPARENT_KEY);
    pix = bg_en_q ? bg_data : BG_COLOR;
    if (o1)      pix = p1_data;
    else if (o2) pix = p2_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= video_on_q ? {pix[15:11], pix[15:13]} : 8'h00;
      vga_g       <= video_on_q ? {pix[10:5],  pix[10:9]}  : 8'h00;
      vga_b       <= video_on_q ? {pix[4:0],   pix[4:2]}   : 8'h00;
      vga_hsync   <= hsync_q;
      vga_vsync   <= vsync_q;
      vga_blank_n <= video_on_q;
    end
  end

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
  // vga_vsync holds the previous stage-2 vsync, so this flags the 1->0 edge in the overlap's own cycle.
  logic seen;
  logic overlap, boundary;

  assign overlap  = o1 && o2 && video_on_q;
  assign boundary = vga_vsync && !vsync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen            <= 1'b0;
      collision_pulse <= 1'b0;
      collision_frame <= 1'b0;
      collision_count <= '0;
    end else begin
      collision_pulse <= boundary && seen;
      if (boundary) begin
        collision_frame <= seen;
        if (seen && collision_count != 8'hFF) collision_count <= collision_count + 8'd1;
      end
      // An overlap on the boundary cycle belongs to the new frame, so set wins over clear.
      if (overlap)       seen <= 1'b1;
      else if (boundary) seen <= 1'b0;
    end
  end
`else
  assign collision_pulse = 1'b0;
  assign collision_frame = 1'b0;
  assign collision_count = 8'h00;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: table of directed pixel vectors plus
// hand-written reset, mid-frame reset and collision-frame sequences.
module tb_sprite_compositor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] current_pixel_x = '0, current_pixel_y = '0;
  logic       video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, bg_en = 1'b0;
  logic [9:0] p1_posx = '0, p1_posy = '0, p2_posx = '0, p2_posy = '0;
  logic [15:0] p1_data = '0, p2_data = '0, bg_data = '0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, vga_blank_n;
  logic       collision_pulse, collision_frame;
  logic [7:0] collision_count;

  int checks = 0;
  int errors = 0;

  sprite_compositor dut (
    .clk(clk), .rst(rst),
    .current_pixel_x(current_pixel_x), .current_pixel_y(current_pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .p1_posx(p1_posx), .p1_posy(p1_posy), .p2_posx(p2_posx), .p2_posy(p2_posy),
    .p1_data(p1_data), .p2_data(p2_data), .bg_data(bg_data), .bg_en(bg_en),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .collision_pulse(collision_pulse), .collision_frame(collision_frame),
    .collision_count(collision_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x, y, p1x, p1y, p2x, p2y;
    logic        vo, hs, vs, be;
    logic [15:0] p1d, p2d, bgd;
    logic [7:0]  er, eg, eb;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(int x, int y, int p1x, int p1y, int p2x, int p2y,
                              int vo, int hs, int vs, int be,
                              int p1d, int p2d, int bgd, int er, int eg, int eb);
    vec_t v;
    v.x = 10'(x);     v.y = 10'(y);
    v.p1x = 10'(p1x); v.p1y = 10'(p1y);
    v.p2x = 10'(p2x); v.p2y = 10'(p2y);
    v.vo = 1'(vo); v.hs = 1'(hs); v.vs = 1'(vs); v.be = 1'(be);
    v.p1d = 16'(p1d); v.p2d = 16'(p2d); v.bgd = 16'(bgd);
    v.er = 8'(er); v.eg = 8'(eg); v.eb = 8'(eb);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Two cycles per vector: x/y/syncs with junk ROM data, then ROM data with inverted
  // control inputs, so only an exact 2-cycle path with 1-cycle ROM alignment matches.
  task automatic apply(input vec_t v, input int idx);
    current_pixel_x = v.x; current_pixel_y = v.y;
    p1_posx = v.p1x; p1_posy = v.p1y; p2_posx = v.p2x; p2_posy = v.p2y;
    video_on = v.vo; hsync_in = v.hs; vsync_in = v.vs; bg_en = v.be;
    p1_data = 16'h5A5A; p2_data = 16'hA5A5; bg_data = 16'h3C3C;
    @(negedge clk);
    current_pixel_x = '0; current_pixel_y = '0;
    video_on = ~v.vo; hsync_in = ~v.hs; vsync_in = ~v.vs; bg_en = ~v.be;
    p1_data = v.p1d; p2_data = v.p2d; bg_data = v.bgd;
    @(negedge clk);
    check($sformatf("v%0d_r", idx), 32'(vga_r), 32'(v.er));
    check($sformatf("v%0d_g", idx), 32'(vga_g), 32'(v.eg));
    check($sformatf("v%0d_b", idx), 32'(vga_b), 32'(v.eb));
    check($sformatf("v%0d_hsync", idx), 32'(vga_hsync), 32'(v.hs));
    check($sformatf("v%0d_vsync", idx), 32'(vga_vsync), 32'(v.vs));
    check($sformatf("v%0d_blank_n", idx), 32'(vga_blank_n), 32'(v.vo));
  endtask

  // One pixel cycle for the collision sequences: drive at a negedge, advance to the next one.
  task automatic cyc(input int x, input logic vo, input logic vs);
    current_pixel_x = 10'(x); current_pixel_y = 10'd5;
    video_on = vo; vsync_in = vs; hsync_in = 1'b1;
    @(negedge clk);
  endtask

  // Short frame: two active pixels at x, then vsync low with video off (boundary registered by the end).
  task automatic frame(input int x);
    cyc(x, 1'b1, 1'b1);
    cyc(x, 1'b1, 1'b1);
    cyc(x, 1'b0, 1'b0);
    cyc(x, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(10,   10,  100, 100, 600, 400, 1, 0, 1, 1, 'hF800, 'h07E0, 'hFFFF, 'hFF, 'hFF, 'hFF);
    vecs[1]  = mk(100,  100, 100, 100, 600, 400, 1, 1, 1, 0, 'hF81F, 'h07E0, 'hFFFF, 'h00, 'h00, 'h00);
    vecs[2]  = mk(100,  100, 100, 100, 600, 400, 1, 1, 1, 0, 'hF800, 'h07E0, 'hFFFF, 'hFF, 'h00, 'h00);
    vecs[3]  = mk(200,  50,  200, 50,  200, 50,  1, 0, 0, 0, 'h001F, 'h07E0, 'hFFFF, 'h00, 'h00, 'hFF);
    vecs[4]  = mk(232,  50,  200, 50,  200, 50,  1, 1, 0, 1, 'h001F, 'h07E0, 'h1234, 'h10, 'h45, 'hA5);
    vecs[5]  = mk(231,  81,  200, 50,  200, 50,  1, 0, 1, 1, 'hF81F, 'h07E0, 'hFFFF, 'h00, 'hFF, 'h00);
    vecs[6]  = mk(5,    0,   1010, 0,  600, 400, 1, 1, 1, 1, 'hF800, 'h07E0, 'h0000, 'hFF, 'h00, 'h00);
    vecs[7]  = mk(1009, 0,   1010, 0,  600, 400, 1, 1, 1, 1, 'hF800, 'h07E0, 'h001F, 'h00, 'h00, 'hFF);
    vecs[8]  = mk(100,  100, 100, 100, 600, 400, 0, 0, 0, 1, 'hF800, 'h07E0, 'hFFFF, 'h00, 'h00, 'h00);
    vecs[9]  = mk(100,  132, 100, 100, 600, 400, 1, 1, 1, 0, 'hF800, 'h07E0, 'hFFFF, 'h00, 'h00, 'h00);
    vecs[10] = mk(100,  131, 100, 100, 600, 400, 1, 1, 1, 0, 'h07E0, 'h001F, 'hFFFF, 'h00, 'hFF, 'h00);
    vecs[11] = mk(101,  101, 100, 100, 600, 400, 1, 0, 1, 0, 'h8410, 'h07E0, 'hFFFF, 'h84, 'h82, 'h84);
    vecs[12] = mk(300,  300, 100, 100, 300, 300, 1, 1, 0, 1, 'hF800, 'h001F, 'hFFFF, 'h00, 'h00, 'hFF);
    vecs[13] = mk(300,  300, 100, 100, 300, 300, 1, 1, 1, 1, 'hF800, 'hF81F, 'h07E0, 'h00, 'hFF, 'h00);

    // Reset held 3 cycles with inputs that would otherwise drive non-reset values.
    video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; bg_en = 1'b1; bg_data = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_r", 32'(vga_r), 32'h0);
    check("rst_g", 32'(vga_g), 32'h0);
    check("rst_b", 32'(vga_b), 32'h0);
    check("rst_hsync", 32'(vga_hsync), 32'h1);
    check("rst_vsync", 32'(vga_vsync), 32'h1);
    check("rst_blank_n", 32'(vga_blank_n), 32'h0);
    check("rst_count", 32'(collision_count), 32'h0);
    check("rst_frame", 32'(collision_frame), 32'h0);
    check("rst_pulse", 32'(collision_pulse), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Mid-frame asynchronous reset, then recovery two cycles after release.
    p1_posx = 10'd600; p1_posy = 10'd400; p2_posx = 10'd600; p2_posy = 10'd400;
    current_pixel_x = 10'd10; current_pixel_y = 10'd10;
    video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; bg_en = 1'b1; bg_data = 16'hFFFF;
    repeat (2) @(negedge clk);
    check("pre_mrst_r", 32'(vga_r), 32'hFF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_r", 32'(vga_r), 32'h0);
    check("mrst_hsync", 32'(vga_hsync), 32'h1);
    check("mrst_vsync", 32'(vga_vsync), 32'h1);
    check("mrst_blank_n", 32'(vga_blank_n), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_1cyc_blank_n", 32'(vga_blank_n), 32'h0);
    @(negedge clk);
    check("mrst_2cyc_blank_n", 32'(vga_blank_n), 32'h1);
    check("mrst_2cyc_r", 32'(vga_r), 32'hFF);
    check("mrst_2cyc_hsync", 32'(vga_hsync), 32'h0);

    // Collision sequences: both sprites at (0,0), both opaque; x=5 overlaps, x=500 misses.
    p1_posx = '0; p1_posy = '0; p2_posx = '0; p2_posy = '0;
    p1_data = 16'hF800; p2_data = 16'h001F; bg_en = 1'b0;
    vsync_in = 1'b1; video_on = 1'b0;
    do_reset();

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    frame(5);
    check("f1_pulse", 32'(collision_pulse), 32'h1);
    check("f1_frame", 32'(collision_frame), 32'h1);
    check("f1_count", 32'(collision_count), 32'd1);
    cyc(500, 1'b1, 1'b1);
    check("f1_pulse_width", 32'(collision_pulse), 32'h0);
    frame(500);
    check("f2_pulse", 32'(collision_pulse), 32'h0);
    check("f2_frame", 32'(collision_frame), 32'h0);
    check("f2_count", 32'(collision_count), 32'd1);
    for (int i = 0; i < 254; i++) frame(5);
    check("sat_reach_count", 32'(collision_count), 32'd255);
    for (int i = 0; i < 46; i++) frame(5);
    check("sat_hold_count", 32'(collision_count), 32'd255);
    check("sat_hold_pulse", 32'(collision_pulse), 32'h1);
    // Overlap only on the boundary cycle: must land in the following frame's status.
    cyc(500, 1'b1, 1'b1);
    cyc(500, 1'b1, 1'b1);
    cyc(5,   1'b1, 1'b0);
    cyc(500, 1'b0, 1'b0);
    check("bnd_frame", 32'(collision_frame), 32'h0);
    check("bnd_pulse", 32'(collision_pulse), 32'h0);
    frame(500);
    check("bnd_next_frame", 32'(collision_frame), 32'h1);
    check("bnd_next_pulse", 32'(collision_pulse), 32'h1);
    check("bnd_next_count", 32'(collision_count), 32'd255);
`else
    frame(5);
    check("nocol_pulse", 32'(collision_pulse), 32'h0);
    check("nocol_frame", 32'(collision_frame), 32'h0);
    frame(5);
    check("nocol_count", 32'(collision_count), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
